// File: rtl/blockc_stream_distributor_if.sv
// blockc_stream_distributor_if: source stream, configuration channel and per-destination
// channel bundle for blockc_stream_distributor.
interface blockc_stream_distributor_if #(
    parameter int DATA_W = 32,
    parameter int NUM_DST = 4
);
    logic src_vld;
    logic src_rdy;
    logic [DATA_W-1:0] src_data;
    logic cfg_req;
    logic [1:0] cfg_mode;
    logic [NUM_DST-1:0] cfg_mask;
    logic cfg_ack;
    logic [NUM_DST-1:0] dst_vld;
    logic [NUM_DST-1:0] dst_rdy;
    logic [NUM_DST*DATA_W-1:0] dst_data;
    logic busy;
    modport master (
        output src_vld, src_data, cfg_req, cfg_mode, cfg_mask, dst_rdy,
        input src_rdy, cfg_ack, dst_vld, dst_data, busy
    );
    modport slave (
        input src_vld, src_data, cfg_req, cfg_mode, cfg_mask, dst_rdy,
        output src_rdy, cfg_ack, dst_vld, dst_data, busy
    );
endinterface

// File: rtl/blockc_stream_distributor.sv
// blockc_stream_distributor: fans one rdy/vld stream out to NUM_DST FIFO channels in
// field-select, round-robin or broadcast mode; BLOCKC_DIST_STATS_EN adds drop_cnt.
module blockc_stream_distributor #(
    parameter int DATA_W = 32,
    parameter int NUM_DST = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int SEL_LSB = 0
) (
    input logic clk,
    input logic rst,
    blockc_stream_distributor_if.slave io
`ifdef BLOCKC_DIST_STATS_EN
    ,
    output logic [15:0] drop_cnt
`endif
);
    localparam int IW = $clog2(NUM_DST);
    localparam int NP = 1 << IW;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, DRAIN, ACK, HOLD} state_t;
    state_t st, nxt;

    logic [1:0] mode;
    logic [NUM_DST-1:0] mask, full, nempty, push, pop;
    logic [IW-1:0] ptr, idx, tgt, rj;
    logic [NP-1:0] maskx, fullx;
    logic sel_ok, xfer;
    logic [CW-1:0] cnt [NUM_DST];
    logic [PW-1:0] wr [NUM_DST];
    logic [PW-1:0] rd [NUM_DST];
    logic [DATA_W-1:0] mem [NUM_DST][FIFO_DEPTH];

    // Padding to a power of two makes out-of-range field indices read as disabled.
    assign maskx = NP'(mask);
    assign fullx = NP'(full);
    assign idx = io.src_data[SEL_LSB +: IW];
    assign sel_ok = maskx[idx];
    assign io.dst_vld = nempty;
    assign io.busy = |nempty || st != IDLE;
    assign io.cfg_ack = st == ACK;

    always_comb begin
        for (int i = 0; i < NUM_DST; i++) begin
            full[i] = cnt[i] == CW'(FIFO_DEPTH);
            nempty[i] = cnt[i] != '0;
        end
    end

    always_comb begin
        tgt = ptr;
        rj = '0;
        for (int k = NUM_DST - 1; k >= 0; k--) begin
            rj = IW'((int'(ptr) + k) % NUM_DST);
            tgt = maskx[rj] ? rj : tgt;
        end
    end

    always_comb begin
        io.src_rdy = !rst && st == IDLE && !io.cfg_req &&
            (mode == 2'd0 ? !(sel_ok && fullx[idx]) :
             mode == 2'd1 ? |mask && !fullx[tgt] :
             mode == 2'd2 ? |mask && !(|(full & mask)) : 1'b0);
        xfer = io.src_vld && io.src_rdy;
        push = !xfer ? '0 :
               mode == 2'd0 ? (sel_ok ? NUM_DST'(1) << idx : '0) :
               mode == 2'd1 ? NUM_DST'(1) << tgt : mask;
        pop = nempty & io.dst_rdy;
    end

    always_comb begin
        io.dst_data = '0;
        for (int i = 0; i < NUM_DST; i++) io.dst_data[i*DATA_W +: DATA_W] = mem[i][rd[i]];
    end

    always_comb begin
        nxt = st;
        nxt = st == IDLE ? (io.cfg_req ? DRAIN : IDLE) :
              st == DRAIN ? (|nempty ? DRAIN : ACK) :
              st == ACK ? HOLD : (io.cfg_req ? HOLD : IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) st <= IDLE;
        else st <= nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode <= 2'd1;
            mask <= '1;
            ptr <= '0;
        end else if (st == ACK) begin
            mode <= io.cfg_mode;
            mask <= io.cfg_mask;
            ptr <= '0;
        end else if (xfer && mode == 2'd1) begin
            ptr <= tgt == IW'(NUM_DST - 1) ? '0 : tgt + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DST; i++) begin
                cnt[i] <= '0;
                wr[i] <= '0;
                rd[i] <= '0;
                for (int j = 0; j < FIFO_DEPTH; j++) mem[i][j] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_DST; i++) begin
                if (push[i]) begin
                    mem[i][wr[i]] <= io.src_data;
                    wr[i] <= wr[i] == PW'(FIFO_DEPTH - 1) ? '0 : wr[i] + 1'b1;
                end
                if (pop[i]) rd[i] <= rd[i] == PW'(FIFO_DEPTH - 1) ? '0 : rd[i] + 1'b1;
                cnt[i] <= cnt[i] + CW'(push[i]) - CW'(pop[i]);
            end
        end
    end

`ifdef BLOCKC_DIST_STATS_EN
    logic drop;
    assign drop = xfer && mode == 2'd0 && !sel_ok;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end
`endif
endmodule

// File: tb/tb_blockc_stream_distributor.sv
// tb_blockc_stream_distributor: randomized stimulus with a queue-based scoreboard; the
// model tracks per-channel contents, mode, mask and RR pointer at transaction level.
module tb_blockc_stream_distributor;
    localparam int DW = 32, N = 4, D = 4, SL = 0;

    logic clk = 0, rst = 1;
    always #5 clk = ~clk;

    blockc_stream_distributor_if #(.DATA_W(DW), .NUM_DST(N)) bus ();
`ifdef BLOCKC_DIST_STATS_EN
    logic [15:0] drop_cnt;
`endif

    blockc_stream_distributor #(.DATA_W(DW), .NUM_DST(N), .FIFO_DEPTH(D), .SEL_LSB(SL)) dut (
        .clk(clk),
        .rst(rst),
        .io(bus)
`ifdef BLOCKC_DIST_STATS_EN
        , .drop_cnt(drop_cnt)
`endif
    );

    int tests = 0, fails = 0;
    logic [DW-1:0] q [N][$];
    logic [DW-1:0] sq [$];
    logic [1:0] m_mode = 2'd1;
    logic [N-1:0] m_mask = '1;
    logic [N-1:0] rdy_fix = '1;
    int m_ptr = 0, phase = 0, acks = 0, m_drops = 0;
    bit xfer_flag = 0, gaps = 0, rand_rdy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int sel_idx(input logic [DW-1:0] d);
        return int'((d >> SL) & ((1 << $clog2(N)) - 1));
    endfunction

    function automatic int rr_tgt();
        for (int k = 0; k < N; k++) if (m_mask[(m_ptr + k) % N]) return (m_ptr + k) % N;
        return -1;
    endfunction

    function automatic bit q_empty();
        for (int i = 0; i < N; i++) if (q[i].size() != 0) return 0;
        return 1;
    endfunction

    function automatic bit exp_rdy();
        int t;
        if (m_mode == 2'd0) begin
            t = sel_idx(bus.src_data);
            if (t < N && m_mask[t]) return q[t].size() < D;
            return 1;
        end
        if (m_mode == 2'd1) begin
            t = rr_tgt();
            return t >= 0 && q[t].size() < D;
        end
        if (m_mode == 2'd2) begin
            if (m_mask == '0) return 0;
            for (int i = 0; i < N; i++) if (m_mask[i] && q[i].size() >= D) return 0;
            return 1;
        end
        return 0;
    endfunction

    // Monitor/scoreboard: all DUT observations taken on the falling edge.
    initial forever begin
        @(negedge clk);
        if (rst) begin
            chk("rst_src_rdy", bus.src_rdy, 0);
            chk("rst_dst_vld", bus.dst_vld, 0);
            chk("rst_busy", bus.busy, 0);
            chk("rst_cfg_ack", bus.cfg_ack, 0);
            chk("rst_dst_data", |bus.dst_data, 0);
`ifdef BLOCKC_DIST_STATS_EN
            chk("rst_drop_cnt", drop_cnt, 0);
`endif
            for (int i = 0; i < N; i++) q[i].delete();
            m_mode = 2'd1;
            m_mask = '1;
            m_ptr = 0;
            phase = 0;
            m_drops = 0;
        end else begin
            bit busy_e, rdy_e, qn;
            logic [DW-1:0] d;
            int t;
            qn = !q_empty();
            busy_e = qn || phase != 0;
            rdy_e = phase == 0 && !bus.cfg_req && exp_rdy();
            chk("busy", bus.busy, busy_e);
            chk("src_rdy", bus.src_rdy, rdy_e);
`ifdef BLOCKC_DIST_STATS_EN
            chk("drop_cnt", drop_cnt, m_drops);
`endif
            for (int i = 0; i < N; i++) begin
                chk($sformatf("dst_vld%0d", i), bus.dst_vld[i], q[i].size() != 0);
                if (bus.dst_vld[i] && q[i].size() != 0) begin
                    chk($sformatf("dst_data%0d", i), bus.dst_data[i*DW +: DW], q[i][0]);
                    if (bus.dst_rdy[i]) void'(q[i].pop_front());
                end
            end
            if (bus.cfg_ack) begin
                chk("ack_phase", phase, 1);
                chk("ack_drained", qn, 0);
                acks++;
                m_mode = bus.cfg_mode;
                m_mask = bus.cfg_mask;
                m_ptr = 0;
                phase = 2;
            end else if (phase == 0 && bus.cfg_req) phase = 1;
            else if (phase == 2 && !bus.cfg_req) phase = 0;
            if (bus.src_vld && bus.src_rdy) begin
                d = bus.src_data;
                xfer_flag = 1;
                if (m_mode == 2'd0) begin
                    t = sel_idx(d);
                    if (t < N && m_mask[t]) q[t].push_back(d);
                    else if (m_drops < 65535) m_drops++;
                end else if (m_mode == 2'd1) begin
                    t = rr_tgt();
                    if (t >= 0) begin
                        q[t].push_back(d);
                        m_ptr = (t + 1) % N;
                    end
                end else begin
                    for (int i = 0; i < N; i++) if (m_mask[i]) q[i].push_back(d);
                end
            end
        end
    end

    // Source driver: presents sq front, holds payload until accepted.
    initial begin
        bus.src_vld = 0;
        bus.src_data = '0;
        forever begin
            @(posedge clk);
            #1;
            if (rst) begin
                xfer_flag = 0;
                bus.src_vld = 0;
            end else begin
                if (xfer_flag) begin
                    if (sq.size() != 0) void'(sq.pop_front());
                    xfer_flag = 0;
                    bus.src_vld = 0;
                end
                if (!bus.src_vld && sq.size() != 0 && (!gaps || $urandom_range(3, 0) != 0)) begin
                    bus.src_vld = 1;
                    bus.src_data = sq[0];
                end
            end
        end
    end

    initial begin
        bus.dst_rdy = '1;
        forever begin
            @(posedge clk);
            #1;
            bus.dst_rdy = rand_rdy ? N'($urandom) : rdy_fix;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((sq.size() != 0 || !q_empty()) && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        chk({name, "_drain_timeout"}, n < 3000, 1);
    endtask

    task automatic cfg(input logic [1:0] md, input logic [N-1:0] mk, input int hold);
        int n = 0;
        @(posedge clk);
        #1;
        bus.cfg_req = 1;
        bus.cfg_mode = md;
        bus.cfg_mask = mk;
        do begin
            @(negedge clk);
            n++;
        end while (!bus.cfg_ack && n < 3000);
        chk("cfg_ack_timeout", n < 3000, 1);
        repeat (hold) @(posedge clk);
        @(posedge clk);
        #1;
        bus.cfg_req = 0;
    endtask

    initial begin
        int a0;
        bus.cfg_req = 0;
        bus.cfg_mode = '0;
        bus.cfg_mask = '0;
        repeat (3) @(negedge clk);
        #2 rst = 0;

        for (int i = 0; i < 8; i++) sq.push_back(32'h10 + 32'(i));
        wait_idle("rr");

        cfg(2'd0, 4'b1011, 0);
        sq.push_back((32'($urandom) & ~32'h3) | 32'h2);
        sq.push_back((32'($urandom) & ~32'h3) | 32'h1);
        wait_idle("sel");
`ifdef BLOCKC_DIST_STATS_EN
        chk("sel_drop_cnt", drop_cnt, 1);
`endif
        gaps = 1;
        rand_rdy = 1;
        for (int i = 0; i < 30; i++) sq.push_back(32'($urandom));
        wait_idle("sel_rand");
        rand_rdy = 0;
        gaps = 0;

        cfg(2'd2, 4'b0101, 0);
        rdy_fix = 4'b1011;
        for (int i = 0; i < 5; i++) sq.push_back(32'($urandom));
        cyc(15);
        chk("bc_stall", sq.size(), 1);
        rdy_fix = '1;
        wait_idle("bc");

        cfg(2'd1, 4'b1111, 0);
        rdy_fix = 4'b1101;
        for (int i = 0; i < 18; i++) sq.push_back(32'($urandom));
        cyc(40);
        chk("rr_stall", sq.size(), 1);
        rdy_fix = '1;
        wait_idle("rr_stall");

        rdy_fix = '0;
        for (int i = 0; i < 3; i++) sq.push_back(32'($urandom));
        cyc(8);
        a0 = acks;
        fork
            cfg(2'd0, 4'b1111, 3);
            begin
                cyc(6);
                rdy_fix = '1;
            end
        join
        chk("single_ack", acks - a0, 1);
        sq.push_back((32'($urandom) & ~32'h3) | 32'h3);
        wait_idle("cfg_drain");

        sq.push_back(32'($urandom));
        cfg(2'd3, 4'b1111, 0);
        cyc(8);
        chk("stall_mode3", sq.size(), 1);
        cfg(2'd1, 4'b0000, 0);
        cyc(8);
        chk("stall_rr_mask0", sq.size(), 1);
        cfg(2'd2, 4'b0000, 0);
        cyc(8);
        chk("stall_bc_mask0", sq.size(), 1);
        cfg(2'd1, 4'b1111, 0);
        wait_idle("stall_release");

        gaps = 1;
        rand_rdy = 1;
        for (int r = 0; r < 6; r++) begin
            cfg(2'($urandom_range(2, 0)), N'($urandom_range(15, 1)), $urandom_range(2, 0));
            for (int i = 0; i < 25; i++) sq.push_back(32'($urandom));
            wait_idle("random");
        end
        rand_rdy = 0;
        gaps = 0;

        cfg(2'd2, 4'b1111, 0);
        rdy_fix = '0;
        sq.push_back(32'($urandom));
        sq.push_back(32'($urandom));
        cyc(6);
        @(negedge clk);
        #2 rst = 1;
        sq.delete();
        @(negedge clk);
        @(negedge clk);
        #2 rst = 0;
        rdy_fix = '1;
        for (int i = 0; i < 6; i++) sq.push_back(32'($urandom));
        wait_idle("post_rst");
        cyc(3);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #900000;
        fails++;
        $display("FAIL watchdog: simulation did not complete in time");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "watchdog");
    end
endmodule
